// File: rtl/bitfusion_pkg.sv
// rtl/bitfusion_pkg.sv - shared constants, FSM state type and saturating add for the psum path
package bitfusion_pkg;

  localparam int ARRAY_SIZE = 8;
  localparam int PSUM_W     = 32;
  localparam int ACC_W      = 40;
  localparam int DEPTH      = 16;
  localparam int CNT_W      = 8;

  typedef enum logic {IDLE, RUN} state_t;

  // Operands arrive already sign-extended to 64 bits; the result is clamped to acc_w bits.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] acc,
                                                 input logic signed [63:0] psum,
                                                 input int acc_w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = acc + psum;
    hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo  = -hi - 64'sd1;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - psum input and finished-row output handshakes
interface psum_accumulator_if #(
  parameter int ARRAY_SIZE = bitfusion_pkg::ARRAY_SIZE,
  parameter int PSUM_W     = bitfusion_pkg::PSUM_W,
  parameter int ACC_W      = bitfusion_pkg::ACC_W,
  parameter int DEPTH      = bitfusion_pkg::DEPTH
);
  localparam int RW = $clog2(DEPTH);

  logic                         psum_valid;
  logic                         psum_ready;
  logic [ARRAY_SIZE*PSUM_W-1:0] psums;
  logic                         out_valid;
  logic                         out_ready;
  logic [ARRAY_SIZE*ACC_W-1:0]  out_data;
  logic [RW-1:0]                out_row;

  modport master (
    output psum_valid, psums, out_ready,
    input  psum_ready, out_valid, out_data, out_row
  );

  modport slave (
    input  psum_valid, psums, out_ready,
    output psum_ready, out_valid, out_data, out_row
  );

endinterface

// File: rtl/psum_acc_lane.sv
// rtl/psum_acc_lane.sv - one lane: signed accumulator plus sign-extended psum, saturated to ACC_W
module psum_acc_lane #(
  parameter int PSUM_W = bitfusion_pkg::PSUM_W,
  parameter int ACC_W  = bitfusion_pkg::ACC_W
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PSUM_W-1:0] psum,
  output logic signed [ACC_W-1:0]  sum
);
  import bitfusion_pkg::*;

  assign sum = ACC_W'(sat_add(64'(acc), 64'(psum), ACC_W));

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - accumulates psum rows across K-tiles and streams finished rows out
module psum_accumulator #(
  parameter int ARRAY_SIZE = bitfusion_pkg::ARRAY_SIZE,
  parameter int PSUM_W     = bitfusion_pkg::PSUM_W,
  parameter int ACC_W      = bitfusion_pkg::ACC_W,
  parameter int DEPTH      = bitfusion_pkg::DEPTH,
  parameter int CNT_W      = bitfusion_pkg::CNT_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [$clog2(DEPTH):0]    cfg_rows,
  input  logic [CNT_W-1:0]          cfg_tiles,
  output logic                      busy,
  output logic                      done,
  psum_accumulator_if.slave         bus
);
  import bitfusion_pkg::*;

  localparam int RW = $clog2(DEPTH);
  localparam int DW = ARRAY_SIZE * ACC_W;
  localparam logic [RW:0] DEPTH_V = (RW + 1)'(DEPTH);

  state_t           state, state_nxt;
  logic [RW:0]      rows_q;
  logic [CNT_W-1:0] tiles_q;
  logic [CNT_W-1:0] tile_idx;
  logic [RW-1:0]    row_idx;
  logic [DW-1:0]    bank [DEPTH];
  logic [DW-1:0]    acc_row;
  logic [DW-1:0]    sum_row;
  logic             first_tile, last_tile, last_row;
  logic             ready, beat, out_fire, final_beat;

  assign first_tile = (tile_idx == '0);
  assign last_tile  = (tile_idx == tiles_q - 1'b1);
  assign last_row   = ({1'b0, row_idx} == rows_q - 1'b1);

  // Only the last tile writes the single out register, so only it waits on the consumer.
  assign ready      = (state == RUN) && (!last_tile || !bus.out_valid || bus.out_ready);
  assign beat       = bus.psum_valid && ready;
  assign out_fire   = bus.out_valid && bus.out_ready;
  assign final_beat = beat && last_tile && last_row;

  assign bus.psum_ready = ready;
  assign busy           = (state == RUN);

  // Tile 0 adds to zero, which reduces the saturating adder to a plain sign extension.
  assign acc_row = first_tile ? '0 : bank[row_idx];

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    psum_acc_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_lane (
      .acc  (acc_row[i*ACC_W +: ACC_W]),
      .psum (bus.psums[i*PSUM_W +: PSUM_W]),
      .sum  (sum_row[i*ACC_W +: ACC_W])
    );
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (final_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rows_q        <= DEPTH_V;
      tiles_q       <= CNT_W'(1);
      row_idx       <= '0;
      tile_idx      <= '0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_row   <= '0;
    end else begin
      state <= state_nxt;
      done  <= final_beat;
      if (state == IDLE && start) begin
        rows_q   <= (cfg_rows == '0 || cfg_rows > DEPTH_V) ? DEPTH_V : cfg_rows;
        tiles_q  <= (cfg_tiles == '0) ? CNT_W'(1) : cfg_tiles;
        row_idx  <= '0;
        tile_idx <= '0;
      end
      if (beat) begin
        if (last_row) begin
          row_idx  <= '0;
          tile_idx <= last_tile ? '0 : tile_idx + 1'b1;
        end else begin
          row_idx <= row_idx + 1'b1;
        end
      end
      if (beat && last_tile) begin
        bus.out_data  <= sum_row;
        bus.out_row   <= row_idx;
        bus.out_valid <= 1'b1;
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && beat && !last_tile) bank[row_idx] <= sum_row;
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - randomized checks of psum_accumulator against a tile-sum reference model
module tb_psum_accumulator;

  localparam int AS    = 8;
  localparam int PW    = 32;
  localparam int AW    = 40;
  localparam int DEPTH = 16;
  localparam longint MAX40 = (64'sd1 <<< 39) - 64'sd1;
  localparam longint MIN40 = -(64'sd1 <<< 39);
  localparam longint MAX32 = (64'sd1 <<< 31) - 64'sd1;
  localparam longint MIN32 = -(64'sd1 <<< 31);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] cfg_rows = '0;
  logic [7:0] cfg_tiles = '0;
  logic       busy, done;
  logic       s_start = 1'b0;
  logic [4:0] s_rows = '0;
  logic [7:0] s_tiles = '0;
  logic       s_busy, s_done;

  int vectors = 0;
  int miscompares = 0;
  int stim [4][16][8];

  psum_accumulator_if #(.ACC_W(AW)) bus ();
  psum_accumulator_if #(.ACC_W(32)) sbus ();

  psum_accumulator #(.ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles),
    .busy(busy), .done(done), .bus(bus)
  );

  psum_accumulator #(.ACC_W(32)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .cfg_rows(s_rows), .cfg_tiles(s_tiles),
    .busy(s_busy), .done(s_done), .bus(sbus)
  );

  always #5 clk = ~clk;

  // Expected finished row: running per-lane sum over tiles, clamped after every add.
  function automatic logic [AS*AW-1:0] model_row(input int r, input int tiles_e);
    logic [AS*AW-1:0] v;
    longint acc;
    v = '0;
    for (int l = 0; l < AS; l++) begin
      acc = longint'(stim[0][r][l]);
      for (int t = 1; t < tiles_e; t++) begin
        acc = acc + longint'(stim[t][r][l]);
        if (acc > MAX40) acc = MAX40;
        else if (acc < MIN40) acc = MIN40;
      end
      v[l*AW +: AW] = acc[AW-1:0];
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int t = 0; t < 4; t++)
      for (int r = 0; r < 16; r++)
        for (int l = 0; l < AS; l++)
          stim[t][r][l] = int'($urandom);
  endtask

  task automatic set_psums(input int t, input int r);
    for (int l = 0; l < AS; l++) bus.psums[l*PW +: PW] = stim[t][r][l];
  endtask

  task automatic pulse_start(input int cr, input int ct);
    cfg_rows  = 5'(cr);
    cfg_tiles = 8'(ct);
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic run_pass(input int cr, input int ct, input int vpct, input int rpct);
    int rows_e, tiles_e, total, nbeat, nout, ndone, cyc, limit;
    rows_e  = (cr == 0 || cr > DEPTH) ? DEPTH : cr;
    tiles_e = (ct == 0) ? 1 : ct;
    total   = rows_e * tiles_e;
    limit   = total * 20 + 100;
    nbeat = 0; nout = 0; ndone = 0; cyc = 0;
    pulse_start(cr, ct);
    while ((nbeat < total || nout < rows_e) && cyc < limit) begin
      bus.psum_valid = (nbeat < total) && (int'($urandom_range(99)) < vpct);
      if (nbeat < total) set_psums(nbeat / rows_e, nbeat % rows_e);
      bus.out_ready = (int'($urandom_range(99)) < rpct);
      #1;
      if (nbeat < (tiles_e - 1) * rows_e) begin
        vectors++;
        if (bus.psum_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL early_tile beat=%0d psum_ready=%b out_valid=%b expected 1/0",
                   nbeat, bus.psum_ready, bus.out_valid);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        vectors++;
        if (bus.out_row !== 4'(nout) || bus.out_data !== model_row(nout, tiles_e)) begin
          miscompares++;
          $display("FAIL out_row%0d row=%0d data=%h expected row=%0d data=%h",
                   nout, bus.out_row, bus.out_data, nout, model_row(nout, tiles_e));
        end
        nout++;
      end
      if (bus.psum_valid && bus.psum_ready === 1'b1) nbeat++;
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
      cyc++;
    end
    bus.psum_valid = 1'b0;
    bus.out_ready  = 1'b0;
    vectors++;
    if (cyc >= limit) begin
      miscompares++;
      $display("FAIL pass_timeout beats=%0d outs=%0d expected %0d/%0d", nbeat, nout, total, rows_e);
    end
    @(posedge clk); #1;
    if (done === 1'b1) ndone++;
    vectors++;
    if (ndone != 1 || busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_end done_pulses=%0d busy=%b out_valid=%b expected 1/0/0",
               ndone, busy, bus.out_valid);
    end
  endtask

  task automatic test_reset();
    bus.psum_valid = 1'b0; bus.out_ready = 1'b0; bus.psums = '0;
    sbus.psum_valid = 1'b0; sbus.out_ready = 1'b0; sbus.psums = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({bus.out_valid, done, busy, bus.psum_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags valid/done/busy/ready=%b expected 0000",
               {bus.out_valid, done, busy, bus.psum_ready});
    end
    vectors++;
    if (bus.out_data !== '0 || bus.out_row !== 4'd0) begin
      miscompares++;
      $display("FAIL reset_out data=%h row=%0d expected 0/0", bus.out_data, bus.out_row);
    end
  endtask

  task automatic test_single_tile();
    for (int l = 0; l < AS; l++) begin
      stim[0][0][l] = 5;
      stim[0][1][l] = -3;
    end
    run_pass(2, 1, 100, 100);
  endtask

  task automatic test_multi_tile();
    fill_random();
    stim[0][0][0] = 10;
    stim[1][0][0] = 20;
    stim[2][0][0] = -5;
    run_pass(1, 3, 70, 100);
  endtask

  task automatic test_saturation();
    int vals [2];
    longint a, s;
    int n;
    bit got;
    vals[0] = 32'h7FFF_FFFF;
    vals[1] = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      a = longint'(vals[k]);
      s = a + a;
      if (s > MAX32) s = MAX32;
      else if (s < MIN32) s = MIN32;
      s_rows = 5'd1; s_tiles = 8'd2; s_start = 1'b1;
      @(posedge clk); #1;
      s_start = 1'b0;
      sbus.psums = '0;
      sbus.psums[31:0] = vals[k];
      sbus.psum_valid = 1'b1;
      sbus.out_ready = 1'b1;
      n = 0; got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        #1;
        if (sbus.out_valid === 1'b1) begin
          got = 1'b1;
          vectors++;
          if (sbus.out_data[31:0] !== s[31:0] || sbus.out_data[63:32] !== 32'd0) begin
            miscompares++;
            $display("FAIL saturate%0d lane0=%h lane1=%h expected %h/0",
                     k, sbus.out_data[31:0], sbus.out_data[63:32], s[31:0]);
          end
        end
        if (sbus.psum_valid && sbus.psum_ready === 1'b1) n++;
        @(posedge clk); #1;
        if (n == 2) sbus.psum_valid = 1'b0;
      end
      if (!got) begin
        vectors++;
        miscompares++;
        $display("FAIL saturate%0d_timeout out_valid=%b expected 1", k, sbus.out_valid);
      end
      sbus.psum_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
    sbus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    fill_random();
    pulse_start(4, 1);
    bus.out_ready = 1'b0;
    bus.psum_valid = 1'b1;
    set_psums(0, 0);
    @(posedge clk); #1;
    set_psums(0, 1);
    for (int h = 0; h < 5; h++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.psum_ready !== 1'b0 || bus.out_row !== 4'd0 ||
          bus.out_data !== model_row(0, 1)) begin
        miscompares++;
        $display("FAIL hold%0d valid=%b ready=%b row=%0d data=%h expected 1/0/0/%h",
                 h, bus.out_valid, bus.psum_ready, bus.out_row, bus.out_data, model_row(0, 1));
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_row !== 4'(k) || bus.out_data !== model_row(k, 1)) begin
        miscompares++;
        $display("FAIL drain%0d valid=%b row=%0d data=%h expected 1/%0d/%h",
                 k, bus.out_valid, bus.out_row, bus.out_data, k, model_row(k, 1));
      end
      if (k < 3) set_psums(0, k + 1);
      else bus.psum_valid = 1'b0;
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_done done=%b expected 1", done);
    end
    @(posedge clk); #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_idle valid=%b busy=%b expected 0/0", bus.out_valid, busy);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_default_cfg();
    fill_random();
    run_pass(0, 0, 80, 60);
  endtask

  task automatic test_reset_midpass();
    fill_random();
    pulse_start(4, 2);
    bus.out_ready = 1'b0;
    bus.psum_valid = 1'b1;
    for (int b = 0; b < 5; b++) begin
      set_psums(b / 4, b % 4);
      @(posedge clk); #1;
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_abort valid=%b busy=%b expected 1/1", bus.out_valid, busy);
    end
    rst = 1'b1;
    bus.psum_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL abort valid=%b busy=%b done=%b expected 0/0/0", bus.out_valid, busy, done);
    end
    for (int l = 0; l < AS; l++) stim[0][0][l] = 7;
    run_pass(1, 1, 100, 100);
  endtask

  task automatic test_random();
    for (int p = 0; p < 5; p++) begin
      fill_random();
      run_pass(int'($urandom_range(20)), int'($urandom_range(4)),
               int'($urandom_range(30, 100)), int'($urandom_range(30, 100)));
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_saturation();
    test_backpressure();
    test_default_cfg();
    test_reset_midpass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
